// File: rtl/edge_sequencer.sv
// edge_sequencer: image-scan control FSM that strobes the load/read/calc/write/move blocks.
// Define SEQ_TIMEOUT_EN to add a 16-bit watchdog that aborts a wait state stuck for 65535 cycles.
module edge_sequencer (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [11:0] width,
    input  logic [11:0] length,
    input  logic        load_done,
    input  logic        read_done,
    input  logic        calc_done,
    input  logic        write_done,
    input  logic        move_done,
    input  logic        all_done,
    output logic        load_initial,
    output logic        start_i_read,
    output logic        start_9_read,
    output logic        start_calc,
    output logic        start_write,
    output logic        start_move,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [23:0] pixel_count
);
    typedef enum logic [2:0] {IDLE, LOAD, IREAD, CALC, WRITE, MOVE, READ9, FIN} state_t;
    state_t      state_q, state_d;
    logic        first_q, ack, dims_ok, accept, reject, entry, timeout;
    logic [11:0] width_q, length_q;
    logic        dims_unused;

    assign dims_ok = width >= 12'd3 && length >= 12'd3;
    assign accept  = state_q == IDLE && start && dims_ok;
    assign reject  = state_q == IDLE && start && !dims_ok;
    assign entry   = state_d != state_q;
    // captured dimensions are held for the image but not consumed by the control path
    assign dims_unused = ^{width_q, length_q};

    // completions are only honoured once the state's strobe cycle has passed
    assign ack = !first_q && ((state_q == LOAD && load_done) ||
                              ((state_q == IREAD || state_q == READ9) && read_done) ||
                              (state_q == CALC && calc_done) ||
                              (state_q == WRITE && write_done) ||
                              (state_q == MOVE && move_done));

    always_comb begin
        case (state_q)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD:    state_d = ack ? IREAD : LOAD;
            IREAD:   state_d = ack ? CALC : IREAD;
            CALC:    state_d = ack ? WRITE : CALC;
            WRITE:   state_d = ack ? (all_done ? FIN : MOVE) : WRITE;
            MOVE:    state_d = ack ? READ9 : MOVE;
            READ9:   state_d = ack ? CALC : READ9;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

`ifdef SEQ_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        wait_st;
    assign wait_st = state_q != IDLE && state_q != FIN;
    assign timeout = wait_st && !ack && cnt_q == 16'hFFFF;
    always_ff @(posedge clk) begin
        if (n_reset || entry) cnt_q <= '0;
        else if (wait_st) cnt_q <= cnt_q + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (n_reset) begin
            state_q      <= IDLE;
            first_q      <= 1'b0;
            load_initial <= 1'b0;
            start_i_read <= 1'b0;
            start_9_read <= 1'b0;
            start_calc   <= 1'b0;
            start_write  <= 1'b0;
            start_move   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            pixel_count  <= '0;
            width_q      <= '0;
            length_q     <= '0;
        end else begin
            state_q      <= state_d;
            first_q      <= entry;
            load_initial <= entry && state_d == LOAD;
            start_i_read <= entry && state_d == IREAD;
            start_9_read <= entry && state_d == READ9;
            start_calc   <= entry && state_d == CALC;
            start_write  <= entry && state_d == WRITE;
            start_move   <= entry && state_d == MOVE;
            busy         <= state_d != IDLE;
            done         <= state_d == FIN;
            error        <= reject || timeout;
            if (accept) begin
                width_q     <= width;
                length_q    <= length;
                pixel_count <= '0;
            end else if (state_q == WRITE && ack && pixel_count != 24'hFFFFFF) begin
                pixel_count <= pixel_count + 24'd1;
            end
        end
    end
endmodule

// File: tb/tb_edge_sequencer.sv
// tb_edge_sequencer: phase/age reference model checked every cycle, plus directed image scenarios.
module tb_edge_sequencer;
    logic        clk = 1'b0, n_reset = 1'b1, start = 1'b0;
    logic [11:0] width = '0, length = '0;
    logic        load_done = 0, read_done = 0, calc_done = 0, write_done = 0, move_done = 0, all_done = 0;
    logic        load_initial, start_i_read, start_9_read, start_calc, start_write, start_move;
    logic        busy, done, error;
    logic [23:0] pixel_count;
    int          vectors = 0, miscompares = 0;
    bit          armed = 0;

    always #5 clk = ~clk;

    edge_sequencer dut (
        .clk(clk), .n_reset(n_reset), .start(start), .width(width), .length(length),
        .load_done(load_done), .read_done(read_done), .calc_done(calc_done),
        .write_done(write_done), .move_done(move_done), .all_done(all_done),
        .load_initial(load_initial), .start_i_read(start_i_read), .start_9_read(start_9_read),
        .start_calc(start_calc), .start_write(start_write), .start_move(start_move),
        .busy(busy), .done(done), .error(error), .pixel_count(pixel_count)
    );

    // model: current phase and number of cycles spent in it
    typedef enum int {M_IDLE, M_LOAD, M_IREAD, M_CALC, M_WRITE, M_MOVE, M_READ9, M_FIN} ph_t;
    ph_t         ph = M_IDLE;
    int          age = 0;
    bit          m_err = 0;
    logic [23:0] m_pc = '0;

    always @(posedge clk) begin : mdl
        ph_t nx;
        bit  h;
        nx = ph;
        h = age > 0;
        m_err = 0;
        if (n_reset) begin
            ph = M_IDLE;
            age = 0;
            m_pc = '0;
        end else begin
            case (ph)
                M_IDLE:  if (start) begin
                             if (width >= 3 && length >= 3) begin nx = M_LOAD; m_pc = '0; end
                             else m_err = 1;
                         end
                M_LOAD:  if (h && load_done) nx = M_IREAD;
                M_IREAD: if (h && read_done) nx = M_CALC;
                M_CALC:  if (h && calc_done) nx = M_WRITE;
                M_WRITE: if (h && write_done) begin
                             nx = all_done ? M_FIN : M_MOVE;
                             if (m_pc != 24'hFFFFFF) m_pc = m_pc + 1;
                         end
                M_MOVE:  if (h && move_done) nx = M_READ9;
                M_READ9: if (h && read_done) nx = M_CALC;
                M_FIN:   nx = M_IDLE;
            endcase
            age = (nx == ph) ? age + 1 : 0;
            ph = nx;
        end
    end

    logic [32:0] exp_v, act_v;
    always @(negedge clk) if (armed) begin
        exp_v = {ph == M_LOAD && age == 0, ph == M_IREAD && age == 0, ph == M_READ9 && age == 0,
                 ph == M_CALC && age == 0, ph == M_WRITE && age == 0, ph == M_MOVE && age == 0,
                 ph != M_IDLE, ph == M_FIN, m_err, m_pc};
        act_v = {load_initial, start_i_read, start_9_read, start_calc, start_write, start_move,
                 busy, done, error, pixel_count};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL model t=%0t dut=%h model=%h", $time, act_v, exp_v);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    int c_li, c_ir, c_calc, c_wr, c_mv, c_r9, c_done, c_err, busy_after, gap, reached;

    // runs one image with completions returned 2 cycles after each strobe
    task automatic run_auto(input int w, input int l, input int nw, input bit early,
                            input bit poke, input bit stop4);
        int del, kind, wc, t_calc, t_wr;
        bit fin_pending;
        del = 0; kind = 0; wc = 0; t_calc = -1; t_wr = -1; fin_pending = 0;
        c_li = 0; c_ir = 0; c_calc = 0; c_wr = 0; c_mv = 0; c_r9 = 0; c_done = 0; c_err = 0;
        busy_after = -1; gap = -1; reached = 0;
        width = w[11:0]; length = l[11:0]; start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 600; k++) begin
            {load_done, read_done, calc_done, write_done, move_done, all_done} = '0;
            start = 0;
            if (del > 0) begin
                del--;
                if (del == 0) case (kind)
                    0: load_done = 1;
                    1: read_done = 1;
                    2: calc_done = 1;
                    3: begin write_done = 1; all_done = (wc == nw); end
                    default: move_done = 1;
                endcase
            end
            c_li += int'(load_initial); c_ir += int'(start_i_read); c_calc += int'(start_calc);
            c_wr += int'(start_write); c_mv += int'(start_move); c_r9 += int'(start_9_read);
            c_err += int'(error);
            if (load_initial) begin del = 2; kind = 0; end
            if (start_i_read || start_9_read) begin del = 2; kind = 1; end
            if (start_calc) begin
                del = 2; kind = 2;
                if (t_calc < 0) t_calc = k;
                if (early) begin calc_done = 1; del = 1; end
            end
            if (start_write) begin
                del = 2; kind = 3; wc++;
                if (t_wr < 0) begin t_wr = k; gap = t_wr - t_calc; end
            end
            if (start_move) begin del = 2; kind = 4; end
            if (poke && start_9_read) begin start = 1; width = 12'd1; length = 12'd1; end
            if (stop4 && start_move && wc == 4) begin reached = 1; break; end
            if (fin_pending) begin busy_after = int'(busy); break; end
            if (done) begin c_done++; fin_pending = 1; end
            tick();
        end
        {load_done, read_done, calc_done, write_done, move_done, all_done} = '0;
        start = 0;
    endtask

    initial begin
        tick();
        armed = 1;
        tick();
        check("reset_outputs", int'({load_initial, start_i_read, start_9_read, start_calc, start_write,
                                     start_move, busy, done, error}), 0);
        check("reset_pixel_count", int'(pixel_count), 0);
        n_reset = 0;
        tick();
        check("first_cycle_no_strobe", int'({load_initial, start_i_read, start_9_read, start_calc,
                                             start_write, start_move}), 0);

        run_auto(5, 5, 9, 0, 0, 0);
        check("img_load_initial", c_li, 1);
        check("img_start_i_read", c_ir, 1);
        check("img_start_calc", c_calc, 9);
        check("img_start_write", c_wr, 9);
        check("img_start_move", c_mv, 8);
        check("img_start_9_read", c_r9, 8);
        check("img_done", c_done, 1);
        check("img_busy_after_fin", busy_after, 0);
        check("img_pixel_count", int'(pixel_count), 9);
        check("img_calc_to_write_gap", gap, 3);
        tick();
        check("idle_holds_pixel_count", int'(pixel_count), 9);

        width = 12'd2; length = 12'd5; start = 1;
        tick();
        start = 0;
        check("reject_error", int'(error), 1);
        check("reject_busy", int'(busy), 0);
        tick();
        check("reject_error_one_cycle", int'(error), 0);
        check("reject_no_strobe", int'({load_initial, busy}), 0);

        run_auto(5, 5, 9, 1, 0, 0);
        check("early_calc_gap", gap, 2);
        check("early_pixel_count", int'(pixel_count), 9);

        run_auto(5, 5, 9, 0, 0, 1);
        check("midscan_reached_move", reached, 1);
        n_reset = 1;
        tick();
        n_reset = 0;
        check("midscan_reset_busy", int'(busy), 0);
        check("midscan_reset_pixel_count", int'(pixel_count), 0);
        run_auto(5, 5, 9, 0, 0, 0);
        check("rerun_load_initial", c_li, 1);
        check("rerun_pixel_count", int'(pixel_count), 9);

        run_auto(5, 5, 9, 0, 1, 0);
        check("busy_start_no_error", c_err, 0);
        check("busy_start_pixel_count", int'(pixel_count), 9);
        check("busy_start_done", c_done, 1);

        for (int i = 0; i < 4000; i++) begin
            start = ($urandom % 4) == 0;
            width = 12'($urandom % 8);
            length = 12'($urandom % 8);
            load_done = ($urandom % 3) == 0;
            read_done = ($urandom % 3) == 0;
            calc_done = ($urandom % 3) == 0;
            write_done = ($urandom % 3) == 0;
            move_done = ($urandom % 3) == 0;
            all_done = ($urandom % 6) == 0;
            n_reset = ($urandom % 300) == 0;
            tick();
        end
        n_reset = 0; start = 0;
        {load_done, read_done, calc_done, write_done, move_done, all_done} = '0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
